id_ex_stage: RTL

- Decode-to-execute pipeline register for the reduced RISC-V pipeline. It sits directly upstream of the ALU and drives its operand, immediate, ALUsrc and ALUctrl inputs.
- It resolves data hazards: EX/MEM and MEM/WB forwarding onto the ALU operands, and load-use stall with bubble insertion.
- It honours downstream hold and branch flush, and keeps a saturating stall counter for performance debug.

---
 rtl/pipe_pkg.sv | 33 +++
 rtl/fwd_mux.sv | 41 ++++
 rtl/id_ex_stage.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the reduced RISC-V pipeline: ALU opcodes, the control
// bundle carried down the pipe, and the forwarding source select.
package pipe_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic [2:0] alu_ctrl;
        logic       alu_src;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
    } ctrl_t;

    // A bubble must never write a register or touch memory.
    localparam ctrl_t BUBBLE = '0;

    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/fwd_mux.sv
// Forwarding selector for one ALU operand: the youngest in-flight producer
// of the source register wins, and x0 is never forwarded.
module fwd_mux
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] rs,
    input  logic [DATA_WIDTH-1:0]     reg_data,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
    input  logic                      exmem_RegWrite,
    input  logic [DATA_WIDTH-1:0]     exmem_result,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
    input  logic                      memwb_RegWrite,
    input  logic [DATA_WIDTH-1:0]     memwb_result,
    output logic [DATA_WIDTH-1:0]     op
);

    fwd_sel_e sel;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        sel = FWD_REG;
        if (exmem_RegWrite && (exmem_rd != '0) && (exmem_rd == rs)) begin
            sel = FWD_EXMEM;
        end else if (memwb_RegWrite && (memwb_rd != '0) && (memwb_rd == rs)) begin
            sel = FWD_MEMWB;
        end
    end

    always_comb begin
        op = reg_data;
        case (sel)
            FWD_EXMEM: op = exmem_result;
            FWD_MEMWB: op = memwb_result;
            default:   op = reg_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use bubble
// insertion, downstream hold, branch flush and a saturating stall counter.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [DATA_WIDTH-1:0]     id_rd1,
    input  logic [DATA_WIDTH-1:0]     id_rd2,
    input  logic [DATA_WIDTH-1:0]     id_imm,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic [2:0]                id_ALUctrl,
    input  logic                      id_ALUsrc,
    input  logic                      id_RegWrite,
    input  logic                      id_MemRead,
    input  logic                      id_MemWrite,
    input  logic                      ex_hold,
    input  logic                      flush,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
    input  logic                      exmem_RegWrite,
    input  logic [DATA_WIDTH-1:0]     exmem_result,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
    input  logic                      memwb_RegWrite,
    input  logic [DATA_WIDTH-1:0]     memwb_result,
    output logic [DATA_WIDTH-1:0]     ALUop1,
    output logic [DATA_WIDTH-1:0]     regOp2,
    output logic [DATA_WIDTH-1:0]     ImmOp,
    output logic [2:0]                ALUctrl,
    output logic                      ALUsrc,
    output logic                      ex_valid,
    output logic                      ex_RegWrite,
    output logic                      ex_MemRead,
    output logic                      ex_MemWrite,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd,
    output logic                      id_stall,
    output logic [CNT_WIDTH-1:0]      stall_count
);

    ctrl_t                     id_ctrl;
    ctrl_t                     ex_ctrl;
    logic [DATA_WIDTH-1:0]     ex_rd1;
    logic [DATA_WIDTH-1:0]     ex_rd2;
    logic [DATA_WIDTH-1:0]     ex_imm;
    logic [REG_ADDR_WIDTH-1:0] ex_rs1;
    logic [REG_ADDR_WIDTH-1:0] ex_rs2;
    logic                      flush_pending;
    logic                      luh;

    assign id_ctrl = '{
        alu_ctrl:  id_ALUctrl,
        alu_src:   id_ALUsrc,
        reg_write: id_RegWrite,
        mem_read:  id_MemRead,
        mem_write: id_MemWrite
    };

    // A load in EX cannot supply its data until MEM/WB, so a dependent
    // instruction in ID must wait one cycle behind a bubble.
    assign luh = ex_valid && ex_ctrl.mem_read && id_valid && (ex_rd != '0)
              && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    assign id_stall = luh || ex_hold;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            ex_valid      <= 1'b0;
            ex_ctrl       <= BUBBLE;
            ex_rd1        <= '0;
            ex_rd2        <= '0;
            ex_imm        <= '0;
            ex_rs1        <= '0;
            ex_rs2        <= '0;
            ex_rd         <= '0;
            flush_pending <= 1'b0;
            stall_count   <= '0;
        end else begin
            if (id_stall && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_WIDTH'(1);
            end

            if (ex_hold) begin
                // The flush cannot act while frozen; remember it for release.
                if (flush) begin
                    flush_pending <= 1'b1;
                end
            end else if (flush || flush_pending) begin
                ex_valid      <= 1'b0;
                ex_ctrl       <= BUBBLE;
                flush_pending <= 1'b0;
            end else if (luh) begin
                ex_valid <= 1'b0;
                ex_ctrl  <= BUBBLE;
            end else begin
                ex_valid <= id_valid;
                ex_ctrl  <= id_valid ? id_ctrl : BUBBLE;
                ex_rd1   <= id_rd1;
                ex_rd2   <= id_rd2;
                ex_imm   <= id_imm;
                ex_rs1   <= id_rs1;
                ex_rs2   <= id_rs2;
                ex_rd    <= id_rd;
            end
        end
    end

    fwd_mux #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_fwd_rs1 (
        .rs             (ex_rs1),
        .reg_data       (ex_rd1),
        .exmem_rd       (exmem_rd),
        .exmem_RegWrite (exmem_RegWrite),
        .exmem_result   (exmem_result),
        .memwb_rd       (memwb_rd),
        .memwb_RegWrite (memwb_RegWrite),
        .memwb_result   (memwb_result),
        .op             (ALUop1)
    );

    fwd_mux #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_fwd_rs2 (
        .rs             (ex_rs2),
        .reg_data       (ex_rd2),
        .exmem_rd       (exmem_rd),
        .exmem_RegWrite (exmem_RegWrite),
        .exmem_result   (exmem_result),
        .memwb_rd       (memwb_rd),
        .memwb_RegWrite (memwb_RegWrite),
        .memwb_result   (memwb_result),
        .op             (regOp2)
    );

    assign ImmOp       = ex_imm;
    assign ALUctrl     = ex_ctrl.alu_ctrl;
    assign ALUsrc      = ex_ctrl.alu_src;
    assign ex_RegWrite = ex_ctrl.reg_write;
    assign ex_MemRead  = ex_ctrl.mem_read;
    assign ex_MemWrite = ex_ctrl.mem_write;

endmodule
